// File: rtl/i2c_csr_pkg.sv
// i2c_csr_pkg: shared constants for the I2C AXI-Lite CSR front-end.
// Register word indices (addr[4:2]), response codes, command word layout
// and STATUS bit positions.
package i2c_csr_pkg;

    // Register word indices, byte offset = index * 4
    localparam logic [2:0] REG_CTRL     = 3'd0;   // 0x00
    localparam logic [2:0] REG_PRESCALE = 3'd1;   // 0x04
    localparam logic [2:0] REG_CMD      = 3'd2;   // 0x08
    localparam logic [2:0] REG_RXDATA   = 3'd3;   // 0x0C
    localparam logic [2:0] REG_STATUS   = 3'd4;   // 0x10

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [15:0] PRESCALE_RESET = 16'h00C7;

    // Command word: {ackn, read, stop, start, byte[7:0]}
    localparam int CMD_WIDTH     = 12;
    localparam int CMD_BYTE_LSB  = 0;
    localparam int CMD_BYTE_MSB  = 7;
    localparam int CMD_START_BIT = 8;
    localparam int CMD_STOP_BIT  = 9;
    localparam int CMD_READ_BIT  = 10;
    localparam int CMD_ACKN_BIT  = 11;

    typedef enum logic [2:0] {
        ST_BUSY      = 3'd0,
        ST_NACK      = 3'd1,
        ST_ARB_LOST  = 3'd2,
        ST_RX_OVR    = 3'd3,
        ST_CMD_FULL  = 3'd4,
        ST_CMD_EMPTY = 3'd5,
        ST_RX_FULL   = 3'd6,
        ST_RX_EMPTY  = 3'd7
    } status_bit_e;

endpackage

// File: rtl/i2c_csr_fifo.sv
// i2c_csr_fifo: synchronous FIFO with flush, full/empty flags and occupancy.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module i2c_csr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array, no reset needed since empty gates every read
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2c_axi_lite_csr.sv
// i2c_axi_lite_csr: AXI4-Lite CSR front-end of the I2C controller.
// Decodes CTRL/PRESCALE/CMD/RXDATA/STATUS, buffers commands and received
// bytes in two FIFOs and keeps sticky status bits.
// Optional build macro: I2C_CSR_IRQ_EN (CTRL.ie read/write and registered irq);
// without it CTRL[1] reads zero and irq is tied low.
module i2c_axi_lite_csr
    import i2c_csr_pkg::*;
#(
    parameter int AXI_WIDTH_ADDR = 32,
    parameter int AXI_WIDTH_DATA = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int RX_DEPTH       = 4
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic [AXI_WIDTH_ADDR-1:0] s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [AXI_WIDTH_DATA-1:0] s_axil_wdata,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [AXI_WIDTH_ADDR-1:0] s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [AXI_WIDTH_DATA-1:0] s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [15:0]               prescale,
    output logic                      core_en,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [CMD_WIDTH-1:0]      cmd_data,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    input  logic                      core_busy,
    input  logic                      core_nack,
    input  logic                      core_arb_lost,
    output logic                      irq
);

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic                      aw_rdy_q;
    logic                      wr_fire;
    logic                      rd_fire;
    logic [2:0]                wr_idx;
    logic [2:0]                rd_idx;
    logic [1:0]                wr_resp;
    logic [1:0]                rd_resp;
    logic [AXI_WIDTH_DATA-1:0] rd_data;
    logic                      w1c_en;

    logic                      ie;
    logic                      en_prev_q;
    logic                      nack_q;
    logic                      arb_q;
    logic                      ovr_q;
    logic [7:0]                status;

    logic                      cmd_push;
    logic                      cmd_pop;
    logic                      cmd_room;
    logic                      cmd_flush;
    logic                      cmd_full;
    logic                      cmd_empty;
    logic [CCW-1:0]            cmd_count;

    logic                      rx_push;
    logic                      rx_pop;
    logic                      rx_full;
    logic                      rx_empty;
    logic [7:0]                rx_head;
    logic [RCW-1:0]            rx_count;

    assign s_axil_awready = aw_rdy_q;
    assign s_axil_wready  = aw_rdy_q;
    assign wr_fire = aw_rdy_q & s_axil_awvalid & s_axil_wvalid;
    assign rd_fire = s_axil_arready & s_axil_arvalid;
    assign wr_idx  = s_axil_awaddr[4:2];
    assign rd_idx  = s_axil_araddr[4:2];
    assign w1c_en  = wr_fire & (wr_idx == REG_STATUS);

    assign cmd_valid = ~cmd_empty & core_en;
    assign cmd_pop   = cmd_valid & cmd_ready;
    assign cmd_room  = ~cmd_full | cmd_pop;
    // Falling edge of CTRL.en drops whatever commands are still queued
    assign cmd_flush = en_prev_q & ~core_en;

    assign rx_push = rx_valid & (~rx_full | rx_pop);

    logic unused_bits;
    assign unused_bits = ^{s_axil_awaddr[AXI_WIDTH_ADDR-1:5], s_axil_awaddr[1:0],
                           s_axil_araddr[AXI_WIDTH_ADDR-1:5], s_axil_araddr[1:0],
                           s_axil_wdata[AXI_WIDTH_DATA-1:16], s_axil_wdata[1],
                           cmd_count, rx_count};

    i2c_csr_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(CMD_WIDTH)) u_cmd_fifo (
        .clk_sys   (axi_aclk),
        .rst       (axi_areset),
        .flush     (cmd_flush),
        .push      (cmd_push),
        .push_data (s_axil_wdata[CMD_WIDTH-1:0]),
        .pop       (cmd_pop),
        .head      (cmd_data),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    i2c_csr_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_sys   (axi_aclk),
        .rst       (axi_areset),
        .flush     (1'b0),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // STATUS word assembly
    always_comb begin
        status               = '0;
        status[ST_BUSY]      = core_busy;
        status[ST_NACK]      = nack_q;
        status[ST_ARB_LOST]  = arb_q;
        status[ST_RX_OVR]    = ovr_q;
        status[ST_CMD_FULL]  = cmd_full;
        status[ST_CMD_EMPTY] = cmd_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_RX_EMPTY]  = rx_empty;
    end

    // Write decode: response code and command FIFO push
    always_comb begin
        wr_resp  = RESP_OKAY;
        cmd_push = 1'b0;
        case (wr_idx)
            REG_CTRL, REG_PRESCALE, REG_RXDATA, REG_STATUS: begin
                wr_resp = RESP_OKAY;
            end
            REG_CMD: begin
                if (cmd_room) cmd_push = wr_fire;
                else          wr_resp  = RESP_SLVERR;
            end
            default: wr_resp = RESP_SLVERR;
        endcase
    end

    // Read decode: data mux, response code and RX pop at accept
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        rx_pop  = 1'b0;
        case (rd_idx)
            REG_CTRL: begin
                rd_data[0] = core_en;
                rd_data[1] = ie;
            end
            REG_PRESCALE: rd_data[15:0] = prescale;
            REG_CMD:      rd_data = '0;
            REG_RXDATA: begin
                if (!rx_empty) begin
                    rd_data[8]   = 1'b1;
                    rd_data[7:0] = rx_head;
                    rx_pop       = rd_fire;
                end
            end
            REG_STATUS:   rd_data[7:0] = status;
            default:      rd_resp = RESP_SLVERR;
        endcase
    end

    // AXI-Lite handshake: single-cycle ready pulses, responses held until taken
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            aw_rdy_q       <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rdata   <= '0;
        end else begin
            aw_rdy_q       <= s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid & ~aw_rdy_q;
            s_axil_arready <= s_axil_arvalid & ~s_axil_rvalid & ~s_axil_arready;
            if (wr_fire) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_resp;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
            if (rd_fire) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rresp  <= rd_resp;
                s_axil_rdata  <= rd_data;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    // CTRL.en and PRESCALE registers
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            core_en   <= 1'b0;
            en_prev_q <= 1'b0;
            prescale  <= PRESCALE_RESET;
        end else begin
            en_prev_q <= core_en;
            if (wr_fire && wr_idx == REG_CTRL)     core_en  <= s_axil_wdata[0];
            if (wr_fire && wr_idx == REG_PRESCALE) prescale <= s_axil_wdata[15:0];
        end
    end

    // Sticky status bits; a set pulse wins over a simultaneous clear
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            nack_q <= 1'b0;
            arb_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            nack_q <= core_nack | (nack_q & ~(w1c_en & s_axil_wdata[ST_NACK]));
            arb_q  <= core_arb_lost | (arb_q & ~(w1c_en & s_axil_wdata[ST_ARB_LOST]));
            ovr_q  <= (rx_valid & rx_full & ~rx_pop) |
                      (ovr_q & ~(w1c_en & s_axil_wdata[ST_RX_OVR]));
        end
    end

`ifdef I2C_CSR_IRQ_EN
    logic ie_q;
    assign ie = ie_q;

    // CTRL.ie register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset)                          ie_q <= 1'b0;
        else if (wr_fire && wr_idx == REG_CTRL)  ie_q <= s_axil_wdata[1];
    end

    // Registered level interrupt
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) irq <= 1'b0;
        else            irq <= ie_q & (~rx_empty | nack_q | arb_q | ovr_q);
    end
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_axi_lite_csr.sv
// tb_i2c_axi_lite_csr: self-checking bench for i2c_axi_lite_csr.
// Table-driven register vectors, hand sequences for FIFO/handshake/irq corners
// and a randomized phase checked against a queue-based model.
module tb_i2c_axi_lite_csr;

`ifdef I2C_CSR_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready;
    logic [15:0] prescale;
    logic        core_en, cmd_valid, cmd_ready;
    logic [11:0] cmd_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        core_busy, core_nack, core_arb_lost, irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i2c_axi_lite_csr dut (
        .axi_aclk(clk), .axi_areset(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .prescale(prescale), .core_en(core_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .core_busy(core_busy), .core_nack(core_nack), .core_arb_lost(core_arb_lost),
        .irq(irq)
    );

    // Monitors: command pops and any write accept while a B response is pending
    logic [11:0] pop_q[$];
    int          aw_while_b = 0;
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) pop_q.push_back(cmd_data);
        if (s_axil_awready && s_axil_bvalid) aw_while_b <= aw_while_b + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout, expected handshake", name);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        s_axil_awaddr = {24'h0, a}; s_axil_wdata = d;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axil_awready && n < 50) begin @(negedge clk); n++; end
        if (!s_axil_awready) begin
            timeout("write_aw");
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; resp = 2'b11;
            return;
        end
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axil_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_axil_bvalid) begin timeout("write_b"); resp = 2'b11; return; end
        resp = s_axil_bresp;
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        s_axil_araddr = {24'h0, a}; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axil_arready && n < 50) begin @(negedge clk); n++; end
        if (!s_axil_arready) begin
            timeout("read_ar"); s_axil_arvalid = 1'b0; d = 32'hDEADBEEF; resp = 2'b11;
            return;
        end
        @(posedge clk); #1;
        s_axil_arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axil_rvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_axil_rvalid) begin timeout("read_r"); d = 32'hDEADBEEF; resp = 2'b11; return; end
        d = s_axil_rdata; resp = s_axil_rresp;
        @(posedge clk); #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) core_nack = 1'b1; else core_arb_lost = 1'b1;
        @(posedge clk); #1;
        core_nack = 1'b0; core_arb_lost = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model for the randomized phase
    logic [11:0] m_cmd[$];
    logic [7:0]  m_rx[$];
    logic [15:0] m_prescale;
    logic        m_nack, m_arb, m_ovr, m_busy;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = m_busy; s[1] = m_nack; s[2] = m_arb; s[3] = m_ovr;
        s[4] = (m_cmd.size() == 4); s[5] = (m_cmd.size() == 0);
        s[6] = (m_rx.size() == 4);  s[7] = (m_rx.size() == 0);
        return s;
    endfunction

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [1:0]  resp;
        logic [31:0] rd;
        int          n, base;
        logic [31:0] d;

        vecs.push_back('{0, 8'h04, 0, 2'b00, 32'h0000_00C7, "rst_prescale"});
        vecs.push_back('{0, 8'h10, 0, 2'b00, 32'h0000_00A0, "rst_status"});
        vecs.push_back('{0, 8'h00, 0, 2'b00, 32'h0000_0000, "rst_ctrl"});
        vecs.push_back('{1, 8'h04, 32'h0000_1234, 2'b00, 0, "wr_prescale"});
        vecs.push_back('{0, 8'h04, 0, 2'b00, 32'h0000_1234, "rd_prescale"});
        vecs.push_back('{1, 8'h04, 32'hABCD_5678, 2'b00, 0, "wr_prescale_hi"});
        vecs.push_back('{0, 8'h04, 0, 2'b00, 32'h0000_5678, "rd_prescale_trunc"});
        vecs.push_back('{0, 8'h1C, 0, 2'b10, 32'h0, "rd_unmapped_1c"});
        vecs.push_back('{1, 8'h18, 32'hFFFF_FFFF, 2'b10, 0, "wr_unmapped_18"});
        vecs.push_back('{0, 8'h14, 0, 2'b10, 32'h0, "rd_unmapped_14"});
        vecs.push_back('{0, 8'h04, 0, 2'b00, 32'h0000_5678, "prescale_kept"});
        vecs.push_back('{1, 8'h0C, 32'h0000_01FF, 2'b00, 0, "wr_rxdata_ro"});
        vecs.push_back('{0, 8'h0C, 0, 2'b00, 32'h0, "rd_rxdata_empty"});
        vecs.push_back('{0, 8'h10, 0, 2'b00, 32'h0000_00A0, "status_kept"});
        vecs.push_back('{1, 8'h00, 32'h0000_0003, 2'b00, 0, "wr_ctrl"});
        vecs.push_back('{0, 8'h00, 0, 2'b00, IRQ_EN ? 32'h3 : 32'h1, "rd_ctrl"});
        vecs.push_back('{1, 8'h00, 32'h0000_0000, 2'b00, 0, "wr_ctrl_off"});

        s_axil_awaddr = '0; s_axil_wdata = '0; s_axil_araddr = '0;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_bready = 0;
        s_axil_arvalid = 0; s_axil_rready = 0;
        cmd_ready = 0; rx_valid = 0; rx_data = '0;
        core_busy = 0; core_nack = 0; core_arb_lost = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", {26'b0, s_axil_awready, s_axil_bvalid, s_axil_arready,
                              s_axil_rvalid, cmd_valid, irq}, 32'h0);
        check("rst_core_en_prescale", {15'b0, core_en, prescale}, 32'h0000_00C7);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, resp);
                check({vecs[i].name, "_resp"}, 32'(resp), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                check({vecs[i].name, "_resp"}, 32'(resp), 32'(vecs[i].exp_resp));
                check({vecs[i].name, "_data"}, rd, vecs[i].exp_rdata);
            end
        end

        // Command FIFO fill, overflow and ordered drain
        axi_write(8'h00, 32'h1, resp);
        for (int i = 0; i < 5; i++) begin
            axi_write(8'h08, 32'h1A0 + i, resp);
            check($sformatf("cmd_push%0d_resp", i), 32'(resp), (i < 4) ? 32'h0 : 32'h2);
        end
        axi_read(8'h10, rd, resp);
        check("cmd_full_status", rd, 32'h0000_0090);
        check("cmd_valid_head", {19'b0, cmd_valid, cmd_data}, 32'h0000_11A0);
        base = pop_q.size();
        cmd_ready = 1'b1;
        wait_cycles(10);
        cmd_ready = 1'b0;
        check("cmd_pop_count", pop_q.size() - base, 4);
        for (int i = 0; i < 4 && base + i < pop_q.size(); i++)
            check($sformatf("cmd_pop%0d", i), 32'(pop_q[base+i]), 32'h1A0 + i);

        // RX overflow: five bytes into a four-deep FIFO
        for (int i = 0; i < 5; i++) rx_push(8'h11 + 8'(i));
        axi_read(8'h10, rd, resp);
        check("rx_full_status", rd, 32'h0000_0068);
        for (int i = 0; i < 5; i++) begin
            axi_read(8'h0C, rd, resp);
            check($sformatf("rx_read%0d", i), rd, (i < 4) ? (32'h111 + i) : 32'h0);
        end
        axi_read(8'h10, rd, resp);
        check("rx_ovr_status", rd, 32'h0000_00A8);
        axi_write(8'h10, 32'h8, resp);
        axi_read(8'h10, rd, resp);
        check("rx_ovr_cleared", rd, 32'h0000_00A0);

        // Held B response blocks a second write, a read still completes
        s_axil_awaddr = 32'h04; s_axil_wdata = 32'h42;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 0;
        n = 0;
        @(negedge clk);
        while (!s_axil_awready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_axil_wdata = 32'h99;
        axi_read(8'h04, rd, resp);
        check("read_during_bhold", rd, 32'h42);
        @(negedge clk);
        check("bhold_state", {30'b0, s_axil_bvalid, s_axil_awready}, 32'h2);
        s_axil_bready = 1'b1;
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axil_awready && n < 50) begin @(negedge clk); n++; end
        check("second_aw_accepted", 32'(s_axil_awready), 32'h1);
        @(posedge clk); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0;
        @(negedge clk);
        check("second_b", {29'b0, s_axil_bvalid, s_axil_bresp}, 32'h4);
        s_axil_bready = 1'b1;
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
        axi_read(8'h04, rd, resp);
        check("second_write_data", rd, 32'h99);

        // Sticky nack/arb_lost and irq
        axi_write(8'h00, 32'h3, resp);
        pulse(0);
        wait_cycles(2);
        check("irq_after_nack", 32'(irq), 32'(IRQ_EN));
        s_axil_awaddr = 32'h10; s_axil_wdata = 32'h2;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 1;
        n = 0;
        @(negedge clk);
        while (!s_axil_awready && n < 50) begin @(negedge clk); n++; end
        core_nack = 1'b1;
        @(posedge clk); #1;
        core_nack = 1'b0; s_axil_awvalid = 0; s_axil_wvalid = 0;
        wait_cycles(1);
        s_axil_bready = 0;
        axi_read(8'h10, rd, resp);
        check("nack_set_beats_w1c", rd, 32'h0000_00A2);
        axi_write(8'h10, 32'h2, resp);
        wait_cycles(2);
        axi_read(8'h10, rd, resp);
        check("nack_cleared", rd, 32'h0000_00A0);
        check("irq_after_clear", 32'(irq), 32'h0);
        pulse(1);
        axi_read(8'h10, rd, resp);
        check("arb_lost_set", rd, 32'h0000_00A4);
        axi_write(8'h10, 32'h4, resp);
        axi_write(8'h00, 32'h0, resp);

        // Randomized phase: en=0, commands accumulate, checked against queues
        m_prescale = 16'h0099; m_nack = 0; m_arb = 0; m_ovr = 0; m_busy = 0;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 7))
                0: begin
                    d = $urandom;
                    axi_write(8'h04, d, resp);
                    m_prescale = d[15:0];
                    check("rnd_prescale_wr", 32'(resp), 32'h0);
                end
                1: begin
                    d = $urandom;
                    axi_write(8'h08, d, resp);
                    check("rnd_cmd_wr", 32'(resp), (m_cmd.size() == 4) ? 32'h2 : 32'h0);
                    if (m_cmd.size() < 4) m_cmd.push_back(d[11:0]);
                end
                2: begin
                    d = $urandom;
                    rx_push(d[7:0]);
                    if (m_rx.size() < 4) m_rx.push_back(d[7:0]); else m_ovr = 1'b1;
                end
                3: begin
                    axi_read(8'h0C, rd, resp);
                    if (m_rx.size() == 0) check("rnd_rx_rd", rd, 32'h0);
                    else check("rnd_rx_rd", rd, {23'b0, 1'b1, m_rx.pop_front()});
                end
                4: begin
                    m_busy = 1'($urandom_range(0, 1));
                    core_busy = m_busy;
                    axi_read(8'h10, rd, resp);
                    check("rnd_status", rd, m_status());
                end
                5: begin
                    if ($urandom_range(0, 1) == 1) begin pulse(0); m_nack = 1'b1; end
                    else begin pulse(1); m_arb = 1'b1; end
                    d = $urandom;
                    axi_write(8'h10, d, resp);
                    if (d[1]) m_nack = 1'b0;
                    if (d[2]) m_arb = 1'b0;
                    if (d[3]) m_ovr = 1'b0;
                end
                6: begin
                    axi_read(8'h04, rd, resp);
                    check("rnd_prescale_rd", rd, {16'b0, m_prescale});
                end
                default: begin
                    axi_read(8'h14 + 8'($urandom_range(0, 2) * 4), rd, resp);
                    check("rnd_unmapped", {rd[29:0], resp}, 32'h2);
                end
            endcase
        end
        axi_read(8'h10, rd, resp);
        check("rnd_final_status", rd, m_status());
        base = pop_q.size();
        cmd_ready = 1'b1;
        axi_write(8'h00, 32'h1, resp);
        wait_cycles(10);
        cmd_ready = 1'b0;
        check("rnd_drain_count", pop_q.size() - base, m_cmd.size());
        for (int i = 0; i < m_cmd.size() && base + i < pop_q.size(); i++)
            check("rnd_drain_order", 32'(pop_q[base+i]), 32'(m_cmd[i]));
        check("no_aw_while_b", aw_while_b, 0);

        // Reset with a pending B response
        s_axil_awaddr = 32'h04; s_axil_wdata = 32'h55;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 0;
        n = 0;
        @(negedge clk);
        while (!s_axil_awready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0;
        rst = 1'b1;
        #2;
        check("reset_midtxn", {14'b0, s_axil_bvalid, s_axil_rvalid, prescale}, 32'h0000_00C7);
        @(posedge clk); #1 rst = 1'b0;
        wait_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
